// File: rtl/mem_read_responder_if.sv
// Bus bundle for mem_read_responder: request channel, BRAM read port,
// response channel and status flags.
interface mem_read_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic              req_ready;

    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_dout;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;

    logic              full;
    logic              empty;
    logic              busy;

    // The responder block itself.
    modport slave (
        input  req_valid, req_addr, req_len, bram_dout, rsp_ready,
        output req_ready, bram_en, bram_addr, rsp_valid, rsp_data,
               full, empty, busy
    );

    // Whoever issues requests, models the BRAM and consumes responses.
    modport master (
        output req_valid, req_addr, req_len, bram_dout, rsp_ready,
        input  req_ready, bram_en, bram_addr, rsp_valid, rsp_data,
               full, empty, busy
    );
endinterface

// File: rtl/mem_read_responder.sv
// Burst read responder: walks a BRAM address range and queues the returned
// words in a response FIFO, issuing reads only when FIFO space is guaranteed.
module mem_read_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk_mem,
    input  logic                  reset,
    mem_read_responder_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
    logic [3:0]        remaining, remaining_nxt;
    logic              inflight;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] buf_mem [DEPTH];

    logic credit;
    logic push;
    logic pop;

    // A read issued now lands one cycle later, so it must be counted
    // against free space before it is issued.
    assign credit = (count + CNT_W'(inflight)) < CNT_W'(DEPTH);
    assign push   = inflight;
    assign pop    = bus.rsp_valid && bus.rsp_ready;

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_nxt     = state;
        cur_addr_nxt  = cur_addr;
        remaining_nxt = remaining;
        bus.req_ready = 1'b0;
        bus.bram_en   = 1'b0;
        bus.bram_addr = cur_addr;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt     = BURST;
                    cur_addr_nxt  = bus.req_addr;
                    remaining_nxt = bus.req_len;
                end
            end
            BURST: begin
                if (credit) begin
                    bus.bram_en   = 1'b1;
                    cur_addr_nxt  = cur_addr + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == 4'd0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk_mem or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            cur_addr  <= cur_addr_nxt;
            remaining <= remaining_nxt;
            inflight  <= bus.bram_en;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing count and
    // pointers already makes its contents unreachable, and a resettable
    // array cannot map onto RAM.
    always_ff @(posedge clk_mem) begin
        if (push) buf_mem[wr_ptr] <= bus.bram_dout;
    end

    assign bus.rsp_valid = (count != '0);
    assign bus.rsp_data  = buf_mem[rd_ptr];
    assign bus.full      = (count == CNT_W'(DEPTH));
    assign bus.empty     = (count == '0);
    assign bus.busy      = (state == BURST) || inflight;
endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder: BRAM model, issue/response monitor,
// and hand-computed expectations for each scenario.
module tb_mem_read_responder;
    logic clk;
    logic reset;

    mem_read_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    mem_read_responder #(.DATA_W(8), .ADDR_W(8), .DEPTH(16)) dut (
        .clk_mem (clk),
        .reset   (reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM contents: data == address, except two marker locations.
    logic [7:0] bram [256];
    initial begin
        for (int i = 0; i < 256; i++) bram[i] = 8'(i);
        bram[8'h10] = 8'hA5;
        bram[8'h40] = 8'h5C;
    end

    always @(posedge clk) begin
        if (bus.bram_en) bus.bram_dout <= bram[bus.bram_addr];
    end

    // Monitor: issued addresses, popped words and the cycles they happened.
    int         cyc;
    logic [7:0] issued [$];
    logic [7:0] got [$];
    int         issue_cyc [$];
    int         pop_cyc [$];
    logic       saw_full;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (bus.bram_en) begin
                issued.push_back(bus.bram_addr);
                issue_cyc.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                got.push_back(bus.rsp_data);
                pop_cyc.push_back(cyc);
            end
            if (bus.full) saw_full = 1'b1;
        end
    end

    int total;
    int bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        issued.delete();
        got.delete();
        issue_cyc.delete();
        pop_cyc.delete();
        saw_full = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".bram_en"},   32'(bus.bram_en),   32'd0);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".full"},      32'(bus.full),      32'd0);
        check({tag, ".empty"},     32'(bus.empty),     32'd1);
        check({tag, ".busy"},      32'(bus.busy),      32'd0);
    endtask

    task automatic send_req(input logic [7:0] addr, input logic [3:0] len);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (!(bus.busy === 1'b0 && bus.empty === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy === 1'b0 && bus.empty === 1'b1), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        saw_full      = 1'b0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_len   = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        check("rst.post_empty", 32'(bus.empty), 32'd1);

        // Single beat at 0x10
        clear_mon();
        bus.rsp_ready = 1'b1;
        send_req(8'h10, 4'd0);
        check("single.bram_en",   32'(bus.bram_en),   32'd1);
        check("single.bram_addr", 32'(bus.bram_addr), 32'h10);
        check("single.req_ready_burst", 32'(bus.req_ready), 32'd0);
        tick();
        check("single.en_drop",   32'(bus.bram_en),   32'd0);
        check("single.idle_ready", 32'(bus.req_ready), 32'd1);
        check("single.busy_inflight", 32'(bus.busy),  32'd1);
        check("single.no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("single.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single.rsp_data",  32'(bus.rsp_data),  32'hA5);
        tick();
        check("single.empty",     32'(bus.empty),     32'd1);
        check("single.busy_done", 32'(bus.busy),      32'd0);
        check("single.n_issue",   32'(issued.size()), 32'd1);

        // Full 16-beat burst from 0x00, consumer always ready
        clear_mon();
        send_req(8'h00, 4'd15);
        wait_done(60, "burst.timeout");
        check("burst.n_issue", 32'(issued.size()), 32'd16);
        check("burst.n_rsp",   32'(got.size()),    32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("burst.addr%0d", i), 32'(issued[i]), 32'(i));
            check($sformatf("burst.data%0d", i), 32'(got[i]),    32'(i));
        end
        check("burst.issue_span", 32'(issue_cyc[15] - issue_cyc[0]), 32'd15);
        check("burst.pop_span",   32'(pop_cyc[15] - pop_cyc[0]),     32'd15);

        // Backpressure: fill the buffer, then a second burst must stall
        clear_mon();
        bus.rsp_ready = 1'b0;
        send_req(8'h20, 4'd15);
        for (int n = 0; n < 40 && bus.full !== 1'b1; n++) tick();
        check("bp.full",  32'(bus.full),  32'd1);
        tick();
        tick();
        check("bp.full_hold", 32'(bus.full),    32'd1);
        check("bp.no_issue",  32'(bus.bram_en), 32'd0);
        check("bp.n_issue16", 32'(issued.size()), 32'd16);
        check("bp.ready_while_full", 32'(bus.req_ready), 32'd1);
        send_req(8'h30, 4'd3);
        check("bp.stall_en",   32'(bus.bram_en),   32'd0);
        check("bp.stall_busy", 32'(bus.busy),      32'd1);
        tick();
        tick();
        check("bp.still_stalled", 32'(bus.bram_en), 32'd0);
        check("bp.still_full",    32'(bus.full),    32'd1);
        bus.rsp_ready = 1'b1;
        wait_done(80, "bp.timeout");
        check("bp.n_rsp", 32'(got.size()), 32'd20);
        for (int i = 0; i < 16; i++)
            check($sformatf("bp.data%0d", i), 32'(got[i]), 32'h20 + 32'(i));
        for (int i = 0; i < 4; i++)
            check($sformatf("bp.data2_%0d", i), 32'(got[16+i]), 32'h30 + 32'(i));

        // Address wrap 0xFE..0x01
        clear_mon();
        send_req(8'hFE, 4'd3);
        wait_done(30, "wrap.timeout");
        check("wrap.n_issue", 32'(issued.size()), 32'd4);
        check("wrap.a0", 32'(issued[0]), 32'hFE);
        check("wrap.a1", 32'(issued[1]), 32'hFF);
        check("wrap.a2", 32'(issued[2]), 32'h00);
        check("wrap.a3", 32'(issued[3]), 32'h01);
        check("wrap.d2", 32'(got[2]),    32'h00);
        check("wrap.d3", 32'(got[3]),    32'h01);

        // Consumer toggling every cycle during a 16-beat burst
        clear_mon();
        send_req(8'h50, 4'd15);
        for (int n = 0; n < 80 && !(bus.busy === 1'b0 && bus.empty === 1'b1); n++) begin
            bus.rsp_ready = ~bus.rsp_ready;
            tick();
        end
        check("toggle.done", 32'(bus.busy === 1'b0 && bus.empty === 1'b1), 32'd1);
        check("toggle.never_full", 32'(saw_full), 32'd0);
        check("toggle.n_rsp", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("toggle.data%0d", i), 32'(got[i]), 32'h50 + 32'(i));

        // Reset mid-burst after five issues
        clear_mon();
        bus.rsp_ready = 1'b0;
        send_req(8'h60, 4'd15);
        for (int n = 0; n < 20 && issued.size() < 5; n++) tick();
        check("midrst.n_issue", 32'(issued.size()), 32'd5);
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        reset = 1'b0;
        clear_mon();
        tick();
        check("midrst.no_write", 32'(bus.empty), 32'd1);
        bus.rsp_ready = 1'b1;
        send_req(8'h40, 4'd0);
        wait_done(20, "midrst.timeout");
        check("midrst.n_issue_new", 32'(issued.size()), 32'd1);
        check("midrst.n_rsp",       32'(got.size()),    32'd1);
        check("midrst.data",        32'(got[0]),        32'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
